// File: rtl/rps_round_master.sv
// ---------------------------------------------------------------------------
// rps_round_master
//
// Round master for the stone-paper-scissors referee. Takes a human move and
// an asynchronous play button, supplies the opponent move, issues one start
// pulse per round, and samples the referee result a fixed number of cycles
// later. It also keeps the match score and declares a best-of-N match winner.
//
// Optional feature macro: RPS_LFSR_OPPONENT_EN
//   defined   : single-player build. The opponent move comes from an 8-bit
//               Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5). p2_move is ignored.
//   undefined : two-player build. The opponent move is p2_move, captured at
//               the press.
//
// Parameters
//   WINS_TO_MATCH  round wins needed to take the match (1..7)
//   RESULT_LAT     cycles from the ref_start cycle to the ref_winner sample (>=1)
//
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   play          asynchronous play button, active-high
//   p1_move[1:0]  human move (00 stone, 01 paper, 10 scissors, 11 invalid)
//   p2_move[1:0]  second-player move (two-player build only)
//   ref_winner    referee result (00 tie, 01 P1, 10 P2, 11 invalid)
//   ref_p1/ref_p2 moves presented to the referee, held until the next capture
//   ref_start     one-cycle start pulse to the referee
//   round_result  last sampled ref_winner
//   round_valid   one-cycle pulse when round_result updates
//   score_p1/p2   rounds won by each player
//   void_err      one-cycle pulse when a round returns 11
//   busy          high while a round is in flight
//   match_done    high from match completion until cleared by a press
//   match_winner  00 none, 01 P1, 10 P2
// ---------------------------------------------------------------------------
module rps_round_master #(
    parameter int WINS_TO_MATCH = 3,
    parameter int RESULT_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play,
    input  logic [1:0] p1_move,
    input  logic [1:0] p2_move,
    input  logic [1:0] ref_winner,
    output logic [1:0] ref_p1,
    output logic [1:0] ref_p2,
    output logic       ref_start,
    output logic [1:0] round_result,
    output logic       round_valid,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic       void_err,
    output logic       busy,
    output logic       match_done,
    output logic [1:0] match_winner
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SCORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Counter is at least one bit wide so RESULT_LAT=1 still builds.
    localparam int              CNT_W     = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LAT - 1);
    localparam logic [2:0]      WIN_SCORE = 3'(WINS_TO_MATCH);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             play_meta;
    logic             play_sync;
    logic             play_prev;
    logic             play_rise;
    logic [1:0]       opp_move;

    // Two-flop synchroniser on the pad input, then a rising-edge detect.
    // NOTE: every clocked block uses non-blocking assignments and an async
    // active-low reset so all flops update together and clear without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            play_meta <= 1'b0;
            play_sync <= 1'b0;
            play_prev <= 1'b0;
        end else begin
            play_meta <= play;
            play_sync <= play_meta;
            play_prev <= play_sync;
        end
    end

    assign play_rise = play_sync & ~play_prev;

`ifdef RPS_LFSR_OPPONENT_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;
    logic       unused_p2_move;

    // x^8 + x^6 + x^5 + x^4, shifting toward the MSB.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end

    // The LFSR can produce 11, which is not a legal move: fold it onto stone.
    assign opp_move       = (lfsr[1:0] == 2'b11) ? 2'b00 : lfsr[1:0];
    assign unused_p2_move = ^p2_move;
`else
    assign opp_move = p2_move;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ref_p1       <= 2'b00;
            ref_p2       <= 2'b00;
            round_result <= 2'b00;
            score_p1     <= 3'd0;
            score_p2     <= 3'd0;
            match_winner <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play_rise) begin
                        ref_p1 <= p1_move;
                        ref_p2 <= opp_move;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        // Scores are updated together with the sample so that
                        // they are already current during the round_valid cycle.
                        round_result <= ref_winner;
                        if (ref_winner == 2'b01) score_p1 <= score_p1 + 3'd1;
                        if (ref_winner == 2'b10) score_p2 <= score_p2 + 3'd1;
                        state <= S_SCORE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_SCORE: begin
                    if (score_p1 == WIN_SCORE) begin
                        match_winner <= 2'b01;
                        state        <= S_DONE;
                    end else if (score_p2 == WIN_SCORE) begin
                        match_winner <= 2'b10;
                        state        <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // This press only clears the match; it does not start a round.
                    if (play_rise) begin
                        score_p1     <= 3'd0;
                        score_p2     <= 3'd0;
                        match_winner <= 2'b00;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pulses and flags are decoded from the state register, so they fall
    // immediately when reset is asserted.
    assign ref_start   = (state == S_ISSUE);
    assign round_valid = (state == S_SCORE);
    assign void_err    = (state == S_SCORE) && (round_result == 2'b11);
    assign busy        = (state == S_ISSUE) || (state == S_WAIT) || (state == S_SCORE);
    assign match_done  = (state == S_DONE);

endmodule

// File: tb/tb_rps_round_master.sv
// ---------------------------------------------------------------------------
// tb_rps_round_master
//
// Directed testbench for rps_round_master with a 2-cycle referee model.
// The default build covers the two-player scenarios. With
// RPS_LFSR_OPPONENT_EN defined, it runs 20 rounds against an LFSR reference
// model instead.
// ---------------------------------------------------------------------------
module tb_rps_round_master;

    logic       clk;
    logic       rst_n;
    logic       play;
    logic [1:0] p1_move;
    logic [1:0] p2_move;
    logic [1:0] ref_winner;
    logic [1:0] ref_p1;
    logic [1:0] ref_p2;
    logic       ref_start;
    logic [1:0] round_result;
    logic       round_valid;
    logic [2:0] score_p1;
    logic [2:0] score_p2;
    logic       void_err;
    logic       busy;
    logic       match_done;
    logic [1:0] match_winner;

    int errors = 0;
    int checks = 0;

    rps_round_master #(.WINS_TO_MATCH(3), .RESULT_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play         (play),
        .p1_move      (p1_move),
        .p2_move      (p2_move),
        .ref_winner   (ref_winner),
        .ref_p1       (ref_p1),
        .ref_p2       (ref_p2),
        .ref_start    (ref_start),
        .round_result (round_result),
        .round_valid  (round_valid),
        .score_p1     (score_p1),
        .score_p2     (score_p2),
        .void_err     (void_err),
        .busy         (busy),
        .match_done   (match_done),
        .match_winner (match_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'b11 || b == 2'b11) return 2'b11;
        if (a == b) return 2'b00;
        if ((a == 2'b00 && b == 2'b10) || (a == 2'b01 && b == 2'b00) ||
            (a == 2'b10 && b == 2'b01)) return 2'b01;
        return 2'b10;
    endfunction

    // Referee model: result computed at ref_start, presented two cycles later
    // and held until the next start.
    logic [1:0] ref_stage;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_stage  <= 2'b00;
            ref_winner <= 2'b00;
        end else begin
            if (ref_start) ref_stage <= rps(ref_p1, ref_p2);
            ref_winner <= ref_stage;
        end
    end

`ifdef RPS_LFSR_OPPONENT_EN
    logic [7:0] lfsr_m;
    logic [7:0] lfsr_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_m    <= 8'hA5;
            lfsr_prev <= 8'hA5;
        end else begin
            lfsr_prev <= lfsr_m;
            lfsr_m    <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    end
`endif

    // Pulse monitor, sampled on the falling edge.
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int start_wide = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int void_cnt = 0;
    logic prev_start = 1'b0;
    logic [1:0] exp_p2 = 2'b00;

    always @(negedge clk) begin
        cyc++;
        if (ref_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (prev_start) start_wide++;
`ifdef RPS_LFSR_OPPONENT_EN
            exp_p2 = (lfsr_prev[1:0] == 2'b11) ? 2'b00 : lfsr_prev[1:0];
`endif
        end
        prev_start = ref_start;
        if (round_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (void_err) void_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic press();
        play = 1'b1;
        repeat (2) tick();
        play = 1'b0;
    endtask

    // Press play and wait, bounded, for the round_valid of that round.
    // Returns inside the SCORE cycle.
    task automatic do_round(input logic [1:0] m1, input logic [1:0] m2);
        int  v0;
        bit  ok;
        v0 = valid_cnt;
        ok = 1'b0;
        p1_move = m1;
        p2_move = m2;
        press();
        for (int i = 0; i < 30 && !ok; i++) begin
            if (valid_cnt != v0) ok = 1'b1;
            else tick();
        end
        check("round_done", 8'(ok), 8'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        int s0;
        int v0;
        rst_n   = 1'b0;
        play    = 1'b0;
        p1_move = 2'b00;
        p2_move = 2'b00;
        repeat (3) tick();

        check("rst_ref_start",    8'(ref_start),    8'd0);
        check("rst_busy",         8'(busy),         8'd0);
        check("rst_ref_p1",       8'(ref_p1),       8'd0);
        check("rst_ref_p2",       8'(ref_p2),       8'd0);
        check("rst_scores",       8'({score_p1, score_p2}), 8'd0);
        check("rst_match_done",   8'(match_done),   8'd0);
        check("rst_match_winner", 8'(match_winner), 8'd0);
        rst_n = 1'b1;
        repeat (2) tick();

`ifdef RPS_LFSR_OPPONENT_EN
        for (int r = 0; r < 20; r++) begin
            do_round(2'(r % 3), 2'b11);
            check("lfsr_ref_p2", 8'(ref_p2), 8'(exp_p2));
            check("ref_p2_not_11", 8'(ref_p2 == 2'b11), 8'd0);
            check("lfsr_result", 8'(round_result), 8'(rps(2'(r % 3), exp_p2)));
            tick();
            if (match_done) begin
                press();
                repeat (6) tick();
            end else begin
                repeat (2) tick();
            end
        end
`else
        // Stone vs scissors: P1 wins.
        do_round(2'b00, 2'b10);
        check("svs_start_width", 8'(start_wide), 8'd0);
        check("svs_start_count", 8'(start_cnt), 8'd1);
        check("svs_latency", 8'(valid_cyc - start_cyc), 8'd3);
        check("svs_result", 8'(round_result), 8'b01);
        check("svs_score_p1", 8'(score_p1), 8'd1);
        check("svs_score_p2", 8'(score_p2), 8'd0);
        check("svs_ref_p1", 8'(ref_p1), 8'b00);
        check("svs_ref_p2", 8'(ref_p2), 8'b10);
        tick();
        check("svs_valid_one_cycle", 8'(round_valid), 8'd0);
        repeat (2) tick();

        // Stone vs paper, then paper vs paper.
        do_reset();
        do_round(2'b00, 2'b01);
        check("svp_result", 8'(round_result), 8'b10);
        check("svp_score_p2", 8'(score_p2), 8'd1);
        repeat (3) tick();
        do_round(2'b01, 2'b01);
        check("tie_result", 8'(round_result), 8'b00);
        check("tie_score_p1", 8'(score_p1), 8'd0);
        check("tie_score_p2", 8'(score_p2), 8'd1);
        repeat (3) tick();

        // Invalid P1 move voids the round.
        v0 = void_cnt;
        do_round(2'b11, 2'b00);
        check("void_result", 8'(round_result), 8'b11);
        check("void_err_pulse", 8'(void_err), 8'd1);
        check("void_score_p1", 8'(score_p1), 8'd0);
        check("void_score_p2", 8'(score_p2), 8'd1);
        tick();
        check("void_err_one_cycle", 8'(void_err), 8'd0);
        check("void_count", 8'(void_cnt - v0), 8'd1);
        repeat (2) tick();

        // Match win: three P1 wins (paper beats stone).
        do_reset();
        for (int r = 0; r < 3; r++) begin
            do_round(2'b01, 2'b00);
            check("match_score_p1", 8'(score_p1), 8'(r + 1));
            tick();
            if (r < 2) begin
                check("match_not_done", 8'(match_done), 8'd0);
                repeat (2) tick();
            end
        end
        check("match_done_set", 8'(match_done), 8'd1);
        check("match_winner_p1", 8'(match_winner), 8'b01);
        check("match_busy_low", 8'(busy), 8'd0);
        s0 = start_cnt;
        press();
        repeat (8) tick();
        check("clear_score_p1", 8'(score_p1), 8'd0);
        check("clear_score_p2", 8'(score_p2), 8'd0);
        check("clear_match_done", 8'(match_done), 8'd0);
        check("clear_match_winner", 8'(match_winner), 8'd0);
        check("clear_no_start", 8'(start_cnt - s0), 8'd0);

        // Second press while busy is dropped.
        do_reset();
        s0 = start_cnt;
        v0 = valid_cnt;
        p1_move = 2'b10;
        p2_move = 2'b01;
        play = 1'b1;
        repeat (2) tick();
        play = 1'b0;
        tick();
        play = 1'b1;
        repeat (2) tick();
        play = 1'b0;
        repeat (15) tick();
        check("busy_press_starts", 8'(start_cnt - s0), 8'd1);
        check("busy_press_valids", 8'(valid_cnt - v0), 8'd1);
        check("busy_press_score_p1", 8'(score_p1), 8'd1);

        // Reset asserted in the middle of WAIT.
        s0 = start_cnt;
        p1_move = 2'b01;
        p2_move = 2'b10;
        press();
        for (int i = 0; i < 20 && start_cnt == s0; i++) tick();
        check("mid_start_seen", 8'(start_cnt - s0), 8'd1);
        tick();
        check("mid_busy_in_wait", 8'(busy), 8'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 8'(busy), 8'd0);
        check("mid_rst_ref_start", 8'(ref_start), 8'd0);
        check("mid_rst_ref_p1", 8'(ref_p1), 8'd0);
        check("mid_rst_ref_p2", 8'(ref_p2), 8'd0);
        check("mid_rst_score_p1", 8'(score_p1), 8'd0);
        check("mid_rst_round_valid", 8'(round_valid), 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        v0 = valid_cnt;
        tick();
        check("mid_no_late_valid", 8'(valid_cnt - v0), 8'd0);

        // The next press after reset is served normally (scissors beats paper).
        do_round(2'b10, 2'b01);
        check("post_rst_result", 8'(round_result), 8'b01);
        check("post_rst_score_p1", 8'(score_p1), 8'd1);
        check("post_rst_score_p2", 8'(score_p2), 8'd0);
        repeat (3) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
